// File: rtl/mem_access_arbiter_pkg.sv
// rtl/mem_access_arbiter_pkg.sv - shared types for the external memory port arbiter
package mem_access_arbiter_pkg;

   localparam int MEM_ARB_NUM_REQ = 3;
   localparam int MEM_ARB_IDX_W   = $clog2(MEM_ARB_NUM_REQ);

   typedef logic [MEM_ARB_IDX_W-1:0] mem_arb_req_index_path_t;

   typedef struct packed {
      logic                    valid;
      mem_arb_req_index_path_t owner;
   } mem_arb_owner_entry_t;

   localparam mem_arb_req_index_path_t MEM_ARB_REQ_ICACHE = mem_arb_req_index_path_t'(0);
   localparam mem_arb_req_index_path_t MEM_ARB_REQ_DCACHE = mem_arb_req_index_path_t'(1);
   localparam mem_arb_req_index_path_t MEM_ARB_REQ_FLUSH  = mem_arb_req_index_path_t'(2);

   // Round-robin successor of a requester index, wrapping at num_req.
   function automatic mem_arb_req_index_path_t mem_arb_next_idx(
      input mem_arb_req_index_path_t idx,
      input int                      num_req
   );
      return (int'(idx) + 1 >= num_req) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_owner_table.sv
// rtl/mem_arb_owner_table.sv - serial-to-owner table with one-cycle response routing
module mem_arb_owner_table
   import mem_access_arbiter_pkg::*;
#(
   parameter int SERIAL_WIDTH = 4,
   parameter int NUM_REQ      = MEM_ARB_NUM_REQ
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_set_valid,
   input  logic [SERIAL_WIDTH-1:0] i_set_serial,
   input  mem_arb_req_index_path_t i_set_owner,
   output logic                    o_busy_at_set,
   input  logic                    i_lookup_valid,
   input  logic [SERIAL_WIDTH-1:0] i_lookup_serial,
   output logic                    o_lookup_miss,
   output logic [NUM_REQ-1:0]      o_rsp
);

   localparam int DEPTH = 2**SERIAL_WIDTH;

   mem_arb_owner_entry_t r_table [DEPTH];
   mem_arb_owner_entry_t w_lookup_entry;
   logic                 w_lookup_hit;
   logic [NUM_REQ-1:0]   r_rsp;

   // Busy reflects the pre-clear state, so a same-serial clear still blocks this cycle.
   assign o_busy_at_set  = r_table[i_set_serial].valid;
   assign w_lookup_entry = r_table[i_lookup_serial];
   assign w_lookup_hit   = i_lookup_valid && w_lookup_entry.valid;
   assign o_lookup_miss  = i_lookup_valid && !w_lookup_entry.valid;
   assign o_rsp          = r_rsp;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_table[i] <= '0;
         end
         r_rsp <= '0;
      end else begin
         r_rsp <= '0;
         if (w_lookup_hit) begin
            r_table[i_lookup_serial].valid <= 1'b0;
            r_rsp <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_lookup_entry.owner;
         end
         if (i_set_valid) begin
            r_table[i_set_serial] <= '{valid: 1'b1, owner: i_set_owner};
         end
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - round-robin arbiter sharing the memory port between cache requesters
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = MEM_ARB_NUM_REQ,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 128,
   parameter int SERIAL_WIDTH = 4
)(
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic [NUM_REQ-1:0]                   i_req_valid,
   input  logic [NUM_REQ-1:0]                   i_req_write,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   i_req_addr,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   i_req_write_data,
   output logic [NUM_REQ-1:0]                   o_req_grant,
   output logic [SERIAL_WIDTH-1:0]              o_req_serial,
   output logic [ADDR_WIDTH-1:0]                o_mem_access_addr,
   output logic [DATA_WIDTH-1:0]                o_mem_access_write_data,
   output logic                                 o_mem_access_re,
   output logic                                 o_mem_access_we,
   input  logic                                 i_mem_access_read_busy,
   input  logic                                 i_mem_access_write_busy,
   input  logic [SERIAL_WIDTH-1:0]              i_next_mem_read_serial,
   input  logic [SERIAL_WIDTH-1:0]              i_next_mem_write_serial,
   input  logic                                 i_mem_read_data_ready,
   input  logic [SERIAL_WIDTH-1:0]              i_mem_read_serial,
   input  logic [DATA_WIDTH-1:0]                i_mem_read_data,
   input  logic                                 i_mem_write_ack_valid,
   input  logic [SERIAL_WIDTH-1:0]              i_mem_write_ack_serial,
   output logic [NUM_REQ-1:0]                   o_rsp_valid,
   output logic [DATA_WIDTH-1:0]                o_rsp_data,
   output logic [NUM_REQ-1:0]                   o_wr_ack,
   output logic                                 o_err_unexpected_rsp
);

   mem_arb_req_index_path_t   r_rr_ptr;
   mem_arb_req_index_path_t   w_winner;
   logic                      w_grant_any;
   logic [NUM_REQ-1:0]        w_eligible;
   logic [MEM_ARB_IDX_W:0]    w_scan_idx;
   logic                      w_rd_busy_at_set;
   logic                      w_wr_busy_at_set;
   logic                      w_rd_miss;
   logic                      w_wr_miss;
   logic [DATA_WIDTH-1:0]     r_rsp_data;
   logic                      r_err;

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (i_req_write[i]) begin
            w_eligible[i] = i_req_valid[i] && !i_mem_access_write_busy && !w_wr_busy_at_set;
         end else begin
            w_eligible[i] = i_req_valid[i] && !i_mem_access_read_busy && !w_rd_busy_at_set;
         end
      end
      if (i_rst) begin
         w_eligible = '0;
      end
   end

   // First eligible index scanning from r_rr_ptr, modulo NUM_REQ.
   always_comb begin
      w_grant_any = 1'b0;
      w_winner    = '0;
      w_scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_scan_idx = {1'b0, r_rr_ptr} + (MEM_ARB_IDX_W+1)'(k);
         if (w_scan_idx >= (MEM_ARB_IDX_W+1)'(NUM_REQ)) begin
            w_scan_idx = w_scan_idx - (MEM_ARB_IDX_W+1)'(NUM_REQ);
         end
         if (!w_grant_any && w_eligible[w_scan_idx[MEM_ARB_IDX_W-1:0]]) begin
            w_grant_any = 1'b1;
            w_winner    = w_scan_idx[MEM_ARB_IDX_W-1:0];
         end
      end
   end

   always_comb begin
      o_req_grant             = '0;
      o_req_serial            = '0;
      o_mem_access_addr       = '0;
      o_mem_access_write_data = '0;
      o_mem_access_re         = 1'b0;
      o_mem_access_we         = 1'b0;
      if (w_grant_any) begin
         o_req_grant[w_winner] = 1'b1;
         o_mem_access_addr     = i_req_addr[w_winner];
         if (i_req_write[w_winner]) begin
            o_mem_access_we         = 1'b1;
            o_mem_access_write_data = i_req_write_data[w_winner];
            o_req_serial            = i_next_mem_write_serial;
         end else begin
            o_mem_access_re = 1'b1;
            o_req_serial    = i_next_mem_read_serial;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rr_ptr <= '0;
      end else if (w_grant_any) begin
         r_rr_ptr <= mem_arb_next_idx(w_winner, NUM_REQ);
      end
   end

   mem_arb_owner_table #(
      .SERIAL_WIDTH (SERIAL_WIDTH),
      .NUM_REQ      (NUM_REQ)
   ) u_read_table (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_set_valid     (o_mem_access_re),
      .i_set_serial    (i_next_mem_read_serial),
      .i_set_owner     (w_winner),
      .o_busy_at_set   (w_rd_busy_at_set),
      .i_lookup_valid  (i_mem_read_data_ready),
      .i_lookup_serial (i_mem_read_serial),
      .o_lookup_miss   (w_rd_miss),
      .o_rsp           (o_rsp_valid)
   );

   mem_arb_owner_table #(
      .SERIAL_WIDTH (SERIAL_WIDTH),
      .NUM_REQ      (NUM_REQ)
   ) u_write_table (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_set_valid     (o_mem_access_we),
      .i_set_serial    (i_next_mem_write_serial),
      .i_set_owner     (w_winner),
      .o_busy_at_set   (w_wr_busy_at_set),
      .i_lookup_valid  (i_mem_write_ack_valid),
      .i_lookup_serial (i_mem_write_ack_serial),
      .o_lookup_miss   (w_wr_miss),
      .o_rsp           (o_wr_ack)
   );

   // Read data is shared by all owners; it only moves when a routed read lands.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rsp_data <= '0;
         r_err      <= 1'b0;
      end else begin
         if (i_mem_read_data_ready && !w_rd_miss) begin
            r_rsp_data <= i_mem_read_data;
         end
         if (w_rd_miss || w_wr_miss) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_rsp_data           = r_rsp_data;
   assign o_err_unexpected_rsp = r_err;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard bench for mem_access_arbiter against a reference model
module tb_mem_access_arbiter;
   import mem_access_arbiter_pkg::*;

   localparam int NR = 3;
   localparam int AW = 32;
   localparam int DW = 128;
   localparam int SW = 4;
   localparam int NS = 16;

   typedef struct {
      int           idx;
      bit           wr;
      logic [SW-1:0] ser;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } gexp_t;

   typedef struct {
      int            due;
      int            owner;
      logic [DW-1:0] data;
   } rexp_t;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NR-1:0]          req_valid;
   logic [NR-1:0]          req_write;
   logic [NR-1:0][AW-1:0]  req_addr;
   logic [NR-1:0][DW-1:0]  req_wdata;
   logic [NR-1:0]          req_grant;
   logic [SW-1:0]          req_serial;
   logic [AW-1:0]          mem_addr;
   logic [DW-1:0]          mem_wdata;
   logic                   mem_re;
   logic                   mem_we;
   logic                   rd_busy;
   logic                   wr_busy;
   logic [SW-1:0]          next_rd;
   logic [SW-1:0]          next_wr;
   logic                   rd_ready;
   logic [SW-1:0]          rd_serial;
   logic [DW-1:0]          rd_data;
   logic                   ack_valid;
   logic [SW-1:0]          ack_serial;
   logic [NR-1:0]          rsp_valid;
   logic [DW-1:0]          rsp_data;
   logic [NR-1:0]          wr_ack;
   logic                   err;

   always #5 clk = ~clk;

   mem_access_arbiter dut (
      .i_clk                   (clk),
      .i_rst                   (rst),
      .i_req_valid             (req_valid),
      .i_req_write             (req_write),
      .i_req_addr              (req_addr),
      .i_req_write_data        (req_wdata),
      .o_req_grant             (req_grant),
      .o_req_serial            (req_serial),
      .o_mem_access_addr       (mem_addr),
      .o_mem_access_write_data (mem_wdata),
      .o_mem_access_re         (mem_re),
      .o_mem_access_we         (mem_we),
      .i_mem_access_read_busy  (rd_busy),
      .i_mem_access_write_busy (wr_busy),
      .i_next_mem_read_serial  (next_rd),
      .i_next_mem_write_serial (next_wr),
      .i_mem_read_data_ready   (rd_ready),
      .i_mem_read_serial       (rd_serial),
      .i_mem_read_data         (rd_data),
      .i_mem_write_ack_valid   (ack_valid),
      .i_mem_write_ack_serial  (ack_serial),
      .o_rsp_valid             (rsp_valid),
      .o_rsp_data              (rsp_data),
      .o_wr_ack                (wr_ack),
      .o_err_unexpected_rsp    (err)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mon_en = 1'b0;

   // Reference state: owner per serial (-1 = free), round-robin pointer, sticky error.
   int m_rd_own [NS];
   int m_wr_own [NS];
   int m_rr;
   bit m_err_cur;
   bit m_err_next;
   int rd_ser;
   int wr_ser;

   bit            p_v [NR];
   bit            p_w [NR];
   logic [AW-1:0] p_a [NR];
   logic [DW-1:0] p_d [NR];

   gexp_t gq[$];
   rexp_t rq[$];
   rexp_t wq[$];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [NR-1:0] onehot(input int i);
      logic [NR-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic int outstanding();
      int n;
      n = 0;
      for (int s = 0; s < NS; s++) begin
         if (m_rd_own[s] >= 0) n++;
         if (m_wr_own[s] >= 0) n++;
      end
      return n;
   endfunction

   gexp_t mg;
   rexp_t mr;

   always @(negedge clk) begin
      if (mon_en) begin
         if (req_grant != '0 || mem_re || mem_we) begin
            if (gq.size() == 0) begin
               chk("grant_spurious", {mem_re, mem_we, req_grant}, '0);
            end else begin
               mg = gq.pop_front();
               chk("grant", req_grant, onehot(mg.idx));
               chk("strobes", {mem_re, mem_we}, {!mg.wr, mg.wr});
               chk("serial", req_serial, mg.ser);
               chk("addr", mem_addr, mg.addr);
               if (mg.wr) chk("wdata", mem_wdata, mg.data);
            end
         end else if (gq.size() != 0) begin
            mg = gq.pop_front();
            chk("grant_missing", req_grant, onehot(mg.idx));
         end
         if (rq.size() != 0 && rq[0].due == cyc) begin
            mr = rq.pop_front();
            chk("rsp_valid", rsp_valid, onehot(mr.owner));
            chk("rsp_data", rsp_data, mr.data);
         end else begin
            chk("rsp_idle", rsp_valid, '0);
         end
         if (wq.size() != 0 && wq[0].due == cyc) begin
            mr = wq.pop_front();
            chk("wr_ack", wr_ack, onehot(mr.owner));
         end else begin
            chk("wr_ack_idle", wr_ack, '0);
         end
         chk("err", err, m_err_cur);
      end
   end

   task automatic step(input int p_new, input int p_wr, input int p_busy, input int p_ret,
                       input int fk, input int fs, input logic [DW-1:0] fd);
      int    win;
      int    idx;
      int    rs;
      int    ws;
      bit    rd_do;
      bit    wr_do;
      bit    el;
      int    cand[$];
      gexp_t g;
      rexp_t r;
      for (int i = 0; i < NR; i++) begin
         if (!rst && !p_v[i] && $urandom_range(99) < p_new) begin
            p_v[i] = 1'b1;
            p_w[i] = ($urandom_range(99) < p_wr);
            p_a[i] = $urandom;
            p_d[i] = {$urandom, $urandom, $urandom, $urandom};
         end
         req_valid[i] = p_v[i];
         req_write[i] = p_w[i];
         req_addr[i]  = p_a[i];
         req_wdata[i] = p_d[i];
      end
      rd_busy = ($urandom_range(99) < p_busy);
      wr_busy = ($urandom_range(99) < p_busy);
      next_rd = SW'(rd_ser);
      next_wr = SW'(wr_ser);
      rd_do = 1'b0;
      wr_do = 1'b0;
      rs = 0;
      ws = 0;
      if (!rst) begin
         if (fk == 1) begin
            rd_do = 1'b1;
            rs = fs;
         end else if ($urandom_range(99) < p_ret) begin
            cand.delete();
            for (int s = 0; s < NS; s++) if (m_rd_own[s] >= 0) cand.push_back(s);
            if (cand.size() > 0) begin
               rd_do = 1'b1;
               rs = cand[$urandom_range(cand.size() - 1)];
            end
         end
         if (fk == 2) begin
            wr_do = 1'b1;
            ws = fs;
         end else if ($urandom_range(99) < p_ret) begin
            cand.delete();
            for (int s = 0; s < NS; s++) if (m_wr_own[s] >= 0) cand.push_back(s);
            if (cand.size() > 0) begin
               wr_do = 1'b1;
               ws = cand[$urandom_range(cand.size() - 1)];
            end
         end
      end
      rd_ready   = rd_do;
      rd_serial  = SW'(rs);
      rd_data    = (fk == 1) ? fd : {$urandom, $urandom, $urandom, $urandom};
      ack_valid  = wr_do;
      ack_serial = SW'(ws);

      win = -1;
      if (!rst) begin
         for (int k = 0; k < NR; k++) begin
            idx = (m_rr + k) % NR;
            if (p_w[idx]) el = p_v[idx] && !wr_busy && (m_wr_own[wr_ser] < 0);
            else          el = p_v[idx] && !rd_busy && (m_rd_own[rd_ser] < 0);
            if (win < 0 && el) win = idx;
         end
      end
      if (rd_do) begin
         if (m_rd_own[rs] >= 0) begin
            r.due = cyc + 1; r.owner = m_rd_own[rs]; r.data = rd_data;
            rq.push_back(r);
            m_rd_own[rs] = -1;
         end else begin
            m_err_next = 1'b1;
         end
      end
      if (wr_do) begin
         if (m_wr_own[ws] >= 0) begin
            r.due = cyc + 1; r.owner = m_wr_own[ws]; r.data = '0;
            wq.push_back(r);
            m_wr_own[ws] = -1;
         end else begin
            m_err_next = 1'b1;
         end
      end
      if (win >= 0) begin
         g.idx = win; g.wr = p_w[win]; g.addr = p_a[win]; g.data = p_d[win];
         if (p_w[win]) begin
            g.ser = SW'(wr_ser);
            m_wr_own[wr_ser] = win;
            wr_ser = (wr_ser + 1) % NS;
         end else begin
            g.ser = SW'(rd_ser);
            m_rd_own[rd_ser] = win;
            rd_ser = (rd_ser + 1) % NS;
         end
         gq.push_back(g);
         m_rr = (win + 1) % NR;
         p_v[win] = 1'b0;
      end
      if (rst) begin
         for (int s = 0; s < NS; s++) begin
            m_rd_own[s] = -1;
            m_wr_own[s] = -1;
         end
         m_rr = 0;
         m_err_next = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      m_err_cur = m_err_next;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NR; i++) p_v[i] = 1'b0;
      rst = 1'b1;
      step(0, 0, 0, 0, 0, 0, '0);
      rst = 1'b0;
      chk("rst_ctrl_outs", {req_grant, mem_re, mem_we, rsp_valid, wr_ack, err, req_serial}, '0);
      chk("rst_addr", mem_addr, '0);
      chk("rst_wdata", mem_wdata, '0);
      chk("rst_rsp_data", rsp_data, '0);
   endtask

   int saved;

   initial begin
      rst = 1'b0;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      rd_busy = 1'b0; wr_busy = 1'b0; next_rd = '0; next_wr = '0;
      rd_ready = 1'b0; rd_serial = '0; rd_data = '0; ack_valid = 1'b0; ack_serial = '0;
      rd_ser = 3;
      wr_ser = 0;
      m_err_cur = 1'b0;
      m_err_next = 1'b0;
      for (int i = 0; i < NR; i++) begin
         p_v[i] = 1'b0; p_w[i] = 1'b0; p_a[i] = '0; p_d[i] = '0;
      end
      do_reset();
      mon_en = 1'b1;

      // single ICache read at serial 3, returned with 0xAB
      p_v[MEM_ARB_REQ_ICACHE] = 1'b1;
      p_w[MEM_ARB_REQ_ICACHE] = 1'b0;
      p_a[MEM_ARB_REQ_ICACHE] = 32'h1000;
      step(0, 0, 0, 0, 0, 0, '0);
      step(0, 0, 0, 0, 1, 3, 128'hAB);
      step(0, 0, 0, 0, 0, 0, '0);

      // all requesters continuously reading
      for (int n = 0; n < 6; n++) step(100, 0, 0, 0, 0, 0, '0);

      // fill the read table, then free the oldest entry
      for (int n = 0; n < 14; n++) step(100, 0, 0, 0, 0, 0, '0);
      step(100, 0, 0, 0, 1, rd_ser, 128'h5A5A);
      for (int n = 0; n < 3; n++) step(100, 0, 0, 0, 0, 0, '0);

      // random traffic with busy gating and responses
      for (int n = 0; n < 400; n++) step(40, 40, 25, 40, 0, 0, '0);

      for (int n = 0; n < 300 && (outstanding() > 0 || p_v[0] || p_v[1] || p_v[2]); n++)
         step(0, 0, 0, 100, 0, 0, '0);
      if (outstanding() != 0) begin
         total++; bad++;
         $display("FAIL drain: outstanding=%0d expected 0", outstanding());
      end

      // write ack for a serial that was never issued
      step(0, 0, 0, 0, 2, 5, '0);
      for (int n = 0; n < 4; n++) step(0, 0, 0, 0, 0, 0, '0);

      // reset with reads in flight
      for (int n = 0; n < 50 && outstanding() < 2; n++) step(60, 0, 0, 0, 0, 0, '0);
      saved = -1;
      for (int s = 0; s < NS; s++) if (saved < 0 && m_rd_own[s] >= 0) saved = s;
      if (saved < 0) begin
         total++; bad++;
         $display("FAIL inflight_setup: no outstanding read");
         saved = 0;
      end
      do_reset();
      step(0, 0, 0, 0, 1, saved, '0);
      step(0, 0, 0, 0, 0, 0, '0);

      for (int i = 0; i < NR; i++) begin
         p_v[i] = 1'b1; p_w[i] = 1'b0; p_a[i] = $urandom;
      end
      for (int n = 0; n < 40; n++) step(50, 50, 20, 50, 0, 0, '0);
      for (int n = 0; n < 3; n++) step(0, 0, 0, 0, 0, 0, '0);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Shares the core's single external memory port between up to `NUM_REQ` requesters: I-cache miss, D-cache miss/writeback, and cache-flush writeback. It sits between those requesters and `MemoryAccessController`. Each cycle it issues at most one read or write using round-robin priority. It records which requester owns each outstanding serial and routes read data and write acknowledgements back to that owner.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (index 0 = ICache, 1 = DCache, 2 = flush)
- `ADDR_WIDTH`, 32, physical address width
- `DATA_WIDTH`, 128, memory entry width
- `SERIAL_WIDTH`, 4, width of read and write serials; each owner table has `2**SERIAL_WIDTH` entries

Ports:
- `clk` in 1: clock
- `rst` in 1: synchronous, active-high reset
- `reqValid` in `NUM_REQ`: per-requester request pending
- `reqWrite` in `NUM_REQ`: 1 = write, 0 = read
- `reqAddr` in `NUM_REQ`×`ADDR_WIDTH`: request address
- `reqWriteData` in `NUM_REQ`×`DATA_WIDTH`: write data
- `reqGrant` out `NUM_REQ`: one-hot, request accepted this cycle
- `reqSerial` out `SERIAL_WIDTH`: serial assigned to the granted request
- `memAccessAddr` out `ADDR_WIDTH`, `memAccessWriteData` out `DATA_WIDTH`, `memAccessRE` out 1, `memAccessWE` out 1: port to memory
- `memAccessReadBusy` in 1, `memAccessWriteBusy` in 1: memory cannot accept a read / write this cycle
- `nextMemReadSerial` in `SERIAL_WIDTH`, `nextMemWriteSerial` in `SERIAL_WIDTH`: serial the next read / write will receive
- `memReadDataReady` in 1, `memReadSerial` in `SERIAL_WIDTH`, `memReadData` in `DATA_WIDTH`: read return
- `memWriteAckValid` in 1, `memWriteAckSerial` in `SERIAL_WIDTH`: write completion
- `rspValid` out `NUM_REQ`: one-hot read data return
- `rspData` out `DATA_WIDTH`: read data, shared by all requesters
- `wrAck` out `NUM_REQ`: one-hot write completion
- `errUnexpectedRsp` out 1: sticky; set when a response arrives for a serial with no valid owner

## Operation
- **Eligibility.** A requester is eligible when all of the following hold:
  - `reqValid` is 1.
  - For a read: `!memAccessReadBusy` and the read owner entry at `nextMemReadSerial` is invalid.
  - For a write: `!memAccessWriteBusy` and the write owner entry at `nextMemWriteSerial` is invalid.
- **Arbitration.** Round-robin pointer `rrPtr` (reset 0). The winner is the first eligible index scanning `rrPtr`, `rrPtr+1`, … modulo `NUM_REQ`. After a grant, `rrPtr` ← (winner+1) mod `NUM_REQ`. With no grant, `rrPtr` holds.
- **Issue.** Combinational in the grant cycle:
  - `reqGrant[w]` = 1.
  - Exactly one of `memAccessRE`/`memAccessWE` = 1.
  - `memAccessAddr`/`memAccessWriteData` driven from requester w.
  - `reqSerial` = the matching next serial.
- **Owner tables.** One read table and one write table, each `2**SERIAL_WIDTH` entries of {valid, owner}. On issue, the entry at the assigned serial is set on the next edge.
- **Read return.** `memReadDataReady` looks up `memReadSerial`. If the entry is valid:
  - Next cycle: `rspValid[owner]` = 1 and `rspData` = `memReadData`.
  - The entry is cleared.
- **Write ack.** Same lookup as read return, producing `wrAck[owner]`.
- **Invalid-entry responses.** A response to an invalid entry is dropped and sets `errUnexpectedRsp`. Only `rst` clears it.
- **Simultaneous set/clear, different serials.** Set and clear on different serials in the same cycle are both applied.
- **Simultaneous set/clear, same serial.** Eligibility uses the pre-clear state, so issue is blocked for that cycle and proceeds the following cycle.
- **Requester contract.** Requesters hold `reqValid` and payload stable until granted.

## Timing
- Issue: 0-cycle latency; grant and memory strobe occur in the same cycle.
- Response routing: 1 cycle from `memReadDataReady`/`memWriteAckValid` to `rspValid`/`wrAck`.
- Throughput: 1 issue per cycle. A read response and a write ack can be routed in the same cycle.
- Reset values:
  - Outputs: all 0, including `reqGrant`, strobes, `rspValid`, `wrAck`, `rspData` and `errUnexpectedRsp`.
  - `rrPtr` = 0.
  - All table entries invalid.
- Reset mid-operation: tables are cleared, so returns of in-flight transactions raise `errUnexpectedRsp`. The flush controller must quiesce memory before asserting `rst`.
- Full table: a requester whose type's table entry at the next serial is still valid is ineligible. Other-type requesters may still win.

## Structure
- Add to the shared `MemoryTypes` package:
  - `MemArbReqIndexPath` (`$clog2(NUM_REQ)` bits)
  - `MemArbOwnerEntry` struct {valid, owner}
  - `MEM_ARB_REQ_ICACHE`/`DCACHE`/`FLUSH` index constants
- Sub-module `mem_arb_owner_table`, instantiated twice (read and write). It has a set port, a lookup/clear port, a `busyAtSet` output and the response-routing register.

## Test plan
- **Single read.** ICache read, addr 0x1000, `nextMemReadSerial`=3 → grant[0], RE=1 and `reqSerial`=3 in the same cycle. Return serial 3, data 0xAB → `rspValid`=001 and `rspData`=0xAB one cycle later.
- **Round-robin.** All three requesters hold reads continuously with no busy → grants 0,1,2,0,1,2.
- **Busy gating.** DCache write with `memAccessWriteBusy`=1 and ICache read pending → ICache granted. DCache is granted in the first cycle busy drops.
- **Table full.** Issue 16 reads without returns → the 17th read (serial wraps to 0, entry valid) is not granted. Return serial 0 → grant occurs in the following cycle.
- **Bad response.** Write ack with serial 5 never issued → no `wrAck`; `errUnexpectedRsp`=1 and stays 1 until `rst`.
- **Reset mid-flight.** Assert `rst` with 2 reads outstanding → all outputs 0 and `rrPtr`=0. A later return for those serials sets `errUnexpectedRsp`.
